mem_access_unit: RTL and testbench

Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MEM pipeline register outputs and runs loads and stores on a single-outstanding req/ack data bus, with little-endian byte-lane steering and load sign/zero extension. Stalls the pipeline through the stall controller while an access is in flight. Presents write-back results to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage of the RV32I pipeline: single-outstanding req/ack data bus,
// little-endian lane steering, load extension and pipeline stall generation.
package mem_access_pkg;
    localparam int REG_WIDTH    = 5;
    localparam int DATA_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LB  = 5'd16;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LH  = 5'd17;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LW  = 5'd18;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LBU = 5'd19;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LHU = 5'd20;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SB  = 5'd21;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SH  = 5'd22;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SW  = 5'd23;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [REG_WIDTH-1:0]    rd,
    input  logic                    rd_op,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [ALU_OP_WIDTH-1:0] aluop,
    input  logic [DATA_WIDTH-1:0]   mem_addr,
    input  logic                    hold,
    output logic                    stall_req,
    output logic                    misalign,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [DATA_WIDTH-1:0]   bus_addr,
    output logic [3:0]              bus_be,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_ack,
    output logic [REG_WIDTH-1:0]    wb_rd,
    output logic                    wb_rd_op,
    output logic [DATA_WIDTH-1:0]   wb_rd_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // size encoding: 0 = byte, 1 = half, 2 = word
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    lane_wdata = {4{d[7:0]}};
            2'd1:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'd0:    load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] data_q, data_d;

    logic       is_load, is_store, is_mem, ld_signed, misalign_c, go;
    logic [1:0] size;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        ld_signed = 1'b0;
        size      = 2'd2;
        case (aluop)
            ALU_LB:  begin is_load  = 1'b1; ld_signed = 1'b1; size = 2'd0; end
            ALU_LH:  begin is_load  = 1'b1; ld_signed = 1'b1; size = 2'd1; end
            ALU_LW:  begin is_load  = 1'b1; size = 2'd2; end
            ALU_LBU: begin is_load  = 1'b1; size = 2'd0; end
            ALU_LHU: begin is_load  = 1'b1; size = 2'd1; end
            ALU_SB:  begin is_store = 1'b1; size = 2'd0; end
            ALU_SH:  begin is_store = 1'b1; size = 2'd1; end
            ALU_SW:  begin is_store = 1'b1; size = 2'd2; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misalign_c = is_mem && (((size == 2'd1) && mem_addr[0]) ||
                                   ((size == 2'd2) && (mem_addr[1:0] != 2'b00)));
    assign go         = is_mem && !misalign_c;
    assign misalign   = misalign_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            data_q      <= data_d;
        end
    end

    // The EX/MEM inputs stay frozen by stall_req/hold until DONE is left,
    // so the address and op can be decoded live in every state.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        data_d      = data_q;
        stall_req   = 1'b0;
        wb_rd       = rd;
        wb_rd_op    = is_mem ? 1'b0 : rd_op;
        wb_rd_data  = rd_data;
        case (state_q)
            IDLE: begin
                if (go) begin
                    stall_req   = 1'b1;
                    state_d     = ACCESS;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_be_d    = lane_be(size, mem_addr[1:0]);
                    bus_wdata_d = lane_wdata(size, rd_data);
                end
            end
            ACCESS: begin
                stall_req = 1'b1;
                if (bus_ack) begin
                    data_d    = load_extract(size, ld_signed, mem_addr[1:0], bus_rdata);
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (is_load) begin
                    wb_rd_op   = rd_op;
                    wb_rd_data = data_q;
                end
                if (!hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset/ack corner sequences
// and randomized ops checked against a behavioural byte-lane model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam logic [4:0] OP_ADD = 5'd0;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  rd;
    logic        rd_op;
    logic [31:0] rd_data;
    logic [4:0]  aluop;
    logic [31:0] mem_addr;
    logic        hold;
    logic        stall_req, misalign, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [4:0]  wb_rd;
    logic        wb_rd_op;
    logic [31:0] wb_rd_data;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .CLK(CLK), .RST(RST), .rd(rd), .rd_op(rd_op), .rd_data(rd_data),
        .aluop(aluop), .mem_addr(mem_addr), .hold(hold),
        .stall_req(stall_req), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wb_rd(wb_rd), .wb_rd_op(wb_rd_op), .wb_rd_data(wb_rd_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdata;
        logic [4:0]  rdn;
        logic        rdop;
        int          waits;
        int          holdn;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        logic        exp_wbop;
        logic        exp_mis;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [4:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            ALU_LW, ALU_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [4:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic bit op_is_signed(input logic [4:0] op);
        return (op == ALU_LB) || (op == ALU_LH);
    endfunction

    // Reference: byte-granular arithmetic over the little-endian word.
    function automatic vec_t model(input logic [4:0] op, input logic [31:0] addr,
                                   input logic [31:0] wdat, input logic [31:0] rdata,
                                   input logic [4:0] rdn, input logic rdop,
                                   input int waits, input int holdn);
        vec_t v;
        int n, off;
        logic [31:0] val, mask;
        n = op_bytes(op);
        off = int'(addr[1:0]);
        v.op = op; v.addr = addr; v.wdat = wdat; v.rdata = rdata;
        v.rdn = rdn; v.rdop = rdop; v.waits = waits; v.holdn = holdn;
        v.exp_mis = (n != 0) && ((off % n) != 0);
        v.exp_be = '0;
        v.exp_wdata = '0;
        if (n != 0) begin
            v.exp_be = 4'(((1 << n) - 1) << off);
            for (int i = 0; i < 4; i++)
                v.exp_wdata[i*8 +: 8] = wdat[(i % n)*8 +: 8];
        end
        val = rdata >> (8 * off);
        if (n != 0 && n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            val = val & mask;
            if (op_is_signed(op) && val[8*n-1]) val = val | ~mask;
        end
        if (n == 0) begin
            v.exp_wb = wdat; v.exp_wbop = rdop;
        end else if (v.exp_mis || op_is_store(op)) begin
            v.exp_wb = wdat; v.exp_wbop = 1'b0;
        end else begin
            v.exp_wb = val; v.exp_wbop = rdop;
        end
        return v;
    endfunction

    // Called just after a rising edge with the unit in IDLE; returns in the same phase.
    task automatic run_vec(input vec_t v);
        int stalls;
        bit mem, aligned, st;
        mem = op_bytes(v.op) != 0;
        aligned = mem && !v.exp_mis;
        st = op_is_store(v.op);
        aluop = v.op; mem_addr = v.addr; rd_data = v.wdat; rd = v.rdn; rd_op = v.rdop;
        hold = 1'b0; bus_ack = 1'b0;
        stalls = 0;
        @(negedge CLK);
        check("misalign", 32'(misalign), 32'(v.exp_mis));
        check("bus_req_idle", 32'(bus_req), 0);
        check("wb_rd", 32'(wb_rd), 32'(v.rdn));
        if (!aligned) begin
            check("stall_nomem", 32'(stall_req), 0);
            check("wb_op_nomem", 32'(wb_rd_op), 32'(v.exp_wbop));
            if (!mem) check("wb_data_pass", wb_rd_data, v.exp_wb);
            @(posedge CLK); #1;
            @(negedge CLK);
            check("bus_req_never", 32'(bus_req), 0);
            check("stall_nomem2", 32'(stall_req), 0);
            @(posedge CLK); #1;
            aluop = OP_ADD;
            return;
        end
        check("wb_op_idle", 32'(wb_rd_op), 0);
        if (stall_req) stalls++;
        for (int k = 0; k <= v.waits; k++) begin
            @(posedge CLK); #1;
            bus_ack = (k == v.waits);
            bus_rdata = (k == v.waits) ? v.rdata : $urandom;
            @(negedge CLK);
            check("bus_req", 32'(bus_req), 1);
            check("bus_we", 32'(bus_we), 32'(st));
            check("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
            check("bus_be", 32'(bus_be), 32'(v.exp_be));
            if (st) check("bus_wdata", bus_wdata, v.exp_wdata);
            check("wb_op_access", 32'(wb_rd_op), 0);
            if (stall_req) stalls++;
        end
        @(posedge CLK); #1;
        bus_rdata = $urandom;
        for (int h = 0; h <= v.holdn; h++) begin
            hold = (h < v.holdn);
            bus_ack = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check("bus_req_done", 32'(bus_req), 0);
            check("stall_done", 32'(stall_req), 0);
            check("wb_op_done", 32'(wb_rd_op), 32'(v.exp_wbop));
            if (!st) check("wb_data_load", wb_rd_data, v.exp_wb);
            @(posedge CLK); #1;
        end
        hold = 1'b0; bus_ack = 1'b0; aluop = OP_ADD;
        check("stall_cycles", 32'(stalls), 32'(v.waits + 2));
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{ALU_LW,  32'h0000_0100, 32'h0000_0000, 32'h1357_9BDF, 5'd1, 1'b1, 0, 2, 4'b1111, 32'h0000_0000, 32'h1357_9BDF, 1'b1, 1'b0};
        tbl[1]  = '{ALU_LB,  32'h0000_0203, 32'h0000_0000, 32'h80FF_FFFF, 5'd2, 1'b1, 0, 0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 1'b1, 1'b0};
        tbl[2]  = '{ALU_LBU, 32'h0000_0203, 32'h0000_0000, 32'h80FF_FFFF, 5'd3, 1'b1, 1, 0, 4'b1000, 32'h0000_0000, 32'h0000_0080, 1'b1, 1'b0};
        tbl[3]  = '{ALU_SH,  32'h0000_0302, 32'h1234_ABCD, 32'h0000_0000, 5'd4, 1'b1, 3, 0, 4'b1100, 32'hABCD_ABCD, 32'h1234_ABCD, 1'b0, 1'b0};
        tbl[4]  = '{ALU_LW,  32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 5'd5, 1'b1, 0, 0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[5]  = '{OP_ADD,  32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 5'd6, 1'b1, 0, 0, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[6]  = '{ALU_LH,  32'h0000_0202, 32'h0000_0000, 32'h8001_0000, 5'd7, 1'b1, 2, 1, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 1'b1, 1'b0};
        tbl[7]  = '{ALU_LHU, 32'h0000_0200, 32'h0000_0000, 32'h1234_F00F, 5'd8, 1'b1, 0, 0, 4'b0011, 32'h0000_0000, 32'h0000_F00F, 1'b1, 1'b0};
        tbl[8]  = '{ALU_SB,  32'h0000_0101, 32'h7777_775A, 32'h0000_0000, 5'd9, 1'b1, 1, 1, 4'b0010, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9]  = '{ALU_SW,  32'h0000_0104, 32'hCAFE_F00D, 32'h0000_0000, 5'd10, 1'b1, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0};
        tbl[10] = '{ALU_LH,  32'h0000_0301, 32'h0000_0000, 32'h0000_0000, 5'd11, 1'b1, 0, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        tbl[11] = '{ALU_LB,  32'h0000_0401, 32'h0000_0000, 32'hAAAA_7FAA, 5'd12, 1'b0, 0, 0, 4'b0010, 32'h0000_0000, 32'h0000_007F, 1'b0, 1'b0};

        RST = 1'b1; aluop = OP_ADD; rd = 5'd0; rd_op = 1'b0; rd_data = 32'h0;
        mem_addr = 32'h0; hold = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        @(posedge CLK); @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_bus_we", 32'(bus_we), 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_be", 32'(bus_be), 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_stall", 32'(stall_req), 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // ack while idle is ignored
        bus_ack = 1'b1;
        @(posedge CLK); #1;
        bus_ack = 1'b0;
        @(negedge CLK);
        check("ack_idle_ignored", 32'(bus_req), 0);
        @(posedge CLK); #1;

        // reset in the middle of an access abandons it
        aluop = ALU_LW; mem_addr = 32'h0000_0100; rd = 5'd1; rd_op = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("pre_rst_bus_req", 32'(bus_req), 1);
        #2;
        RST = 1'b1; aluop = OP_ADD;
        #1;
        check("rst_async_bus_req", 32'(bus_req), 0);
        check("rst_async_addr", bus_addr, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_bus_req", 32'(bus_req), 0);
        check("post_rst_stall", 32'(stall_req), 0);
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            int r;
            logic [4:0] op;
            vec_t v;
            r = $urandom_range(0, 11);
            op = (r < 8) ? 5'(16 + r) : 5'(r);
            v = model(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 2));
            run_vec(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
